// File: rtl/cypher_lock_pkg.sv
`default_nettype none
// ============================================================
// cypher_lock_pkg : shared state encoding and width helpers
// Rev 1.0
// ============================================================
package cypher_lock_pkg;

  typedef enum logic [1:0] {
    S_UNARMED = 2'd0,
    S_ENTRY   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic int cnt_width(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cypher_lock_if.sv
`default_nettype none
// ============================================================
// cypher_lock_if : digit entry valid/ready handshake
// Rev 1.0
// ============================================================
interface cypher_lock_if #(
  parameter int DIGIT_W = 4
);
  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               digit_ready;

  modport master (output digit, output digit_valid, input  digit_ready);
  modport slave  (input  digit, input  digit_valid, output digit_ready);
endinterface
`default_nettype wire

// File: rtl/lockout_timer.sv
`default_nettype none
// ============================================================
// lockout_timer : loadable down-counter, done when it reaches 0
// Rev 1.0
// ============================================================
module lockout_timer #(
  parameter int LOCKOUT_CYC = 16
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic load_i,
  input  wire logic count_i,
  output logic      done_o
);
  localparam int W = $clog2(LOCKOUT_CYC + 1);

  logic [W-1:0] count_q;

  // Loading LOCKOUT_CYC-1 makes done rise after exactly LOCKOUT_CYC cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= W'(LOCKOUT_CYC - 1);
    end else if (count_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/cypher_lock.sv
`default_nettype none
// ============================================================
// cypher_lock : N-digit code lock with failure counter and lockout
// Rev 1.0
// ============================================================
module cypher_lock
  import cypher_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  localparam int IDX_W      = idx_width(DIGITS),
  localparam int CNT_W      = cnt_width(MAX_FAIL)
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_ni,
  cypher_lock_if.slave                   dig_if,
  input  wire logic [DIGITS*DIGIT_W-1:0] cypher_i,
  input  wire logic                      cypher_load_i,
  input  wire logic                      entry_clear_i,
  input  wire logic                      relock_i,
  output logic      [IDX_W-1:0]          digit_index_o,
  output logic                           result_valid_o,
  output logic                           result_pass_o,
  output logic                           unlocked_o,
  output logic                           locked_out_o,
  output logic      [CNT_W-1:0]          fail_count_o
);

  state_e                    state_q, state_d;
  logic [DIGITS*DIGIT_W-1:0] cypher_q, cypher_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      mis_q, mis_d;
  logic [CNT_W-1:0]          fail_q, fail_d;
  logic                      res_valid_q, res_valid_d;
  logic                      res_pass_q, res_pass_d;
  logic                      unlocked_q, locked_q;
  logic                      w_timer_load, w_timer_done, w_mis_now;
  logic [CNT_W-1:0]          w_fail_inc;
  logic [DIGIT_W-1:0]        w_digits [DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_split
    assign w_digits[k] = cypher_q[k*DIGIT_W +: DIGIT_W];
  end

  assign w_mis_now  = mis_q | (dig_if.digit != w_digits[idx_q]);
  assign w_fail_inc = fail_q + 1'b1;

  lockout_timer #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_timer_load),
    .count_i (state_q == S_LOCKOUT),
    .done_o  (w_timer_done)
  );

  always_comb begin
    state_d      = state_q;
    cypher_d     = cypher_q;
    idx_d        = idx_q;
    mis_d        = mis_q;
    fail_d       = fail_q;
    res_valid_d  = 1'b0;
    res_pass_d   = res_pass_q;
    w_timer_load = 1'b0;
    case (state_q)
      S_UNARMED, S_OPEN: begin
        if (cypher_load_i) begin
          cypher_d = cypher_i;
          fail_d   = '0;
          idx_d    = '0;
          mis_d    = 1'b0;
          state_d  = S_ENTRY;
        end else if (relock_i && (state_q == S_OPEN)) begin
          idx_d   = '0;
          mis_d   = 1'b0;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A clear discards any digit offered in the same cycle.
        if (entry_clear_i) begin
          idx_d = '0;
          mis_d = 1'b0;
        end else if (dig_if.digit_valid) begin
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            res_valid_d = 1'b1;
            res_pass_d  = ~w_mis_now;
            idx_d       = '0;
            mis_d       = 1'b0;
            if (!w_mis_now) begin
              fail_d  = '0;
              state_d = S_OPEN;
            end else begin
              fail_d = w_fail_inc;
              if (w_fail_inc == CNT_W'(MAX_FAIL)) begin
                w_timer_load = 1'b1;
                state_d      = S_LOCKOUT;
              end
            end
          end else begin
            idx_d = idx_q + 1'b1;
            mis_d = w_mis_now;
          end
        end
      end
      S_LOCKOUT: begin
        if (w_timer_done) begin
          fail_d  = '0;
          idx_d   = '0;
          mis_d   = 1'b0;
          state_d = S_ENTRY;
        end
      end
      default: state_d = S_UNARMED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_UNARMED;
      cypher_q    <= '0;
      idx_q       <= '0;
      mis_q       <= 1'b0;
      fail_q      <= '0;
      res_valid_q <= 1'b0;
      res_pass_q  <= 1'b0;
      unlocked_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cypher_q    <= cypher_d;
      idx_q       <= idx_d;
      mis_q       <= mis_d;
      fail_q      <= fail_d;
      res_valid_q <= res_valid_d;
      res_pass_q  <= res_pass_d;
      unlocked_q  <= (state_d == S_OPEN);
      locked_q    <= (state_d == S_LOCKOUT);
    end
  end

  assign dig_if.digit_ready = (state_q == S_ENTRY);
  assign digit_index_o      = idx_q;
  assign result_valid_o     = res_valid_q;
  assign result_pass_o      = res_pass_q;
  assign unlocked_o         = unlocked_q;
  assign locked_out_o       = locked_q;
  assign fail_count_o       = fail_q;
endmodule
`default_nettype wire
